// File: rtl/l2_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l2_mem_arbiter_pkg : shared types/constants for the I/D-cache L2 arbiter  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package l2_mem_arbiter_pkg;

  localparam int c_max_gnt_cyc = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/l2_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l2_mem_arbiter : round-robin I-cache/D-cache arbiter for one L2 port      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module l2_mem_arbiter
  import l2_mem_arbiter_pkg::*;
#(
  parameter int MAX_GNT_CYC = c_max_gnt_cyc
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ic_req,
  input  logic        dc_req,
  input  logic [31:0] ic_addr,
  input  logic [31:0] dc_addr,
  input  logic        ic_rd_en,
  input  logic        dc_rd_en,
  input  logic        ic_wr_en,
  input  logic        dc_wr_en,
  input  logic [31:0] ic_wr_data,
  input  logic [31:0] dc_wr_data,
  output logic        ic_gnt,
  output logic        dc_gnt,
  output logic        ic_rd_vld,
  output logic        dc_rd_vld,
  output logic [31:0] rd_data,
  output logic        timeout,
  output logic [31:0] l2_mem_access_addr,
  output logic        l2_mem_rd_en,
  output logic        l2_mem_wr_en,
  output logic [31:0] l2_mem_wr_data,
  input  logic [31:0] l2_mem_rd_data
);

  localparam logic [4:0] c_cnt_last = 5'(MAX_GNT_CYC - 1);

  arb_state_t r_state;
  req_id_t    r_ptr;
  logic [4:0] r_cnt;

  assign ic_gnt  = (r_state == GNT_IC);
  assign dc_gnt  = (r_state == GNT_DC);
  assign rd_data = l2_mem_rd_data;

  // The owner's strobes reach L2; a non-granted requester is fully masked.
  always_comb begin
    l2_mem_access_addr = '0;
    l2_mem_rd_en       = 1'b0;
    l2_mem_wr_en       = 1'b0;
    l2_mem_wr_data     = '0;
    case (r_state)
      GNT_IC: begin
        l2_mem_access_addr = ic_addr;
        l2_mem_rd_en       = ic_rd_en;
        l2_mem_wr_en       = ic_wr_en;
        l2_mem_wr_data     = ic_wr_data;
      end
      GNT_DC: begin
        l2_mem_access_addr = dc_addr;
        l2_mem_rd_en       = dc_rd_en;
        l2_mem_wr_en       = dc_wr_en;
        l2_mem_wr_data     = dc_wr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= REQ_IC;
      r_cnt     <= '0;
      timeout   <= 1'b0;
      ic_rd_vld <= 1'b0;
      dc_rd_vld <= 1'b0;
    end else begin
      // Tag follows the issuing owner, so a last-cycle read survives handoff.
      ic_rd_vld <= l2_mem_rd_en && (r_state == GNT_IC);
      dc_rd_vld <= l2_mem_rd_en && (r_state == GNT_DC);
      timeout   <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (ic_req && (!dc_req || r_ptr == REQ_IC)) begin
            r_state <= GNT_IC;
          end else if (dc_req) begin
            r_state <= GNT_DC;
          end
        end
        GNT_IC: begin
          if (ic_req && r_cnt != c_cnt_last) begin
            r_cnt <= r_cnt + 5'd1;
          end else begin
            r_cnt   <= '0;
            r_ptr   <= REQ_DC;
            timeout <= ic_req;
            r_state <= dc_req ? GNT_DC : IDLE;
          end
        end
        GNT_DC: begin
          if (dc_req && r_cnt != c_cnt_last) begin
            r_cnt <= r_cnt + 5'd1;
          end else begin
            r_cnt   <= '0;
            r_ptr   <= REQ_IC;
            timeout <= dc_req;
            r_state <= ic_req ? GNT_IC : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_l2_mem_arbiter : directed self-checking bench for l2_mem_arbiter       |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_l2_mem_arbiter;

  localparam int MAXG = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req = 1'b0, dc_req = 1'b0;
  logic [31:0] ic_addr = '0, dc_addr = '0;
  logic        ic_rd_en = 1'b0, dc_rd_en = 1'b0;
  logic        ic_wr_en = 1'b0, dc_wr_en = 1'b0;
  logic [31:0] ic_wr_data = '0, dc_wr_data = '0;
  logic        ic_gnt, dc_gnt, ic_rd_vld, dc_rd_vld, timeout;
  logic [31:0] rd_data, l2_mem_access_addr, l2_mem_wr_data;
  logic        l2_mem_rd_en, l2_mem_wr_en;
  logic [31:0] l2_mem_rd_data = '0;

  int checks = 0;
  int failures = 0;

  l2_mem_arbiter #(.MAX_GNT_CYC(MAXG)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .dc_req(dc_req),
    .ic_addr(ic_addr), .dc_addr(dc_addr),
    .ic_rd_en(ic_rd_en), .dc_rd_en(dc_rd_en),
    .ic_wr_en(ic_wr_en), .dc_wr_en(dc_wr_en),
    .ic_wr_data(ic_wr_data), .dc_wr_data(dc_wr_data),
    .ic_gnt(ic_gnt), .dc_gnt(dc_gnt),
    .ic_rd_vld(ic_rd_vld), .dc_rd_vld(dc_rd_vld),
    .rd_data(rd_data), .timeout(timeout),
    .l2_mem_access_addr(l2_mem_access_addr), .l2_mem_rd_en(l2_mem_rd_en),
    .l2_mem_wr_en(l2_mem_wr_en), .l2_mem_wr_data(l2_mem_wr_data),
    .l2_mem_rd_data(l2_mem_rd_data)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // L2 memory: returns a fixed address-derived word one cycle after a read.
  initial forever begin
    @(posedge clk);
    l2_mem_rd_data <= l2_mem_rd_en ? mem_word(l2_mem_access_addr) : 32'h0;
  end

  // Behavioural model: owner 0=none, 1=IC, 2=DC; held = granted cycles so far.
  typedef struct {
    int owner;
    bit prefer_dc;
    int held;
    bit to;
  } mstate_t;

  function automatic mstate_t model_next(input mstate_t s, input logic icr, input logic dcr);
    mstate_t n;
    logic    still, waiting;
    n    = s;
    n.to = 1'b0;
    if (s.owner == 0) begin
      if (icr && dcr) n.owner = s.prefer_dc ? 2 : 1;
      else if (icr)   n.owner = 1;
      else if (dcr)   n.owner = 2;
      n.held = (n.owner != 0) ? 1 : 0;
    end else begin
      still   = (s.owner == 1) ? icr : dcr;
      waiting = (s.owner == 1) ? dcr : icr;
      if (still && s.held < MAXG) begin
        n.held = s.held + 1;
      end else begin
        n.to        = still;
        n.prefer_dc = (s.owner == 1);
        n.owner     = waiting ? 3 - s.owner : 0;
        n.held      = waiting ? 1 : 0;
      end
    end
    return n;
  endfunction

  mstate_t     m = '{owner: 0, prefer_dc: 1'b0, held: 0, to: 1'b0};
  bit          m_icv = 1'b0, m_dcv = 1'b0;
  logic [31:0] m_rd_addr = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m     = '{owner: 0, prefer_dc: 1'b0, held: 0, to: 1'b0};
      m_icv = 1'b0;
      m_dcv = 1'b0;
    end else begin
      m_icv     = (m.owner == 1) && ic_rd_en;
      m_dcv     = (m.owner == 2) && dc_rd_en;
      m_rd_addr = (m.owner == 1) ? ic_addr : dc_addr;
      m         = model_next(m, ic_req, dc_req);
    end
  end

  int ic_vld_cnt = 0, dc_gnt_cnt = 0, to_cnt = 0, to_ic_cnt = 0, bad_wr_cnt = 0;

  initial forever begin
    @(negedge clk);
    check1("ic_gnt", ic_gnt, m.owner == 1);
    check1("dc_gnt", dc_gnt, m.owner == 2);
    check1("timeout", timeout, m.to);
    check1("ic_rd_vld", ic_rd_vld, m_icv);
    check1("dc_rd_vld", dc_rd_vld, m_dcv);
    check32("l2_addr", l2_mem_access_addr,
            (m.owner == 1) ? ic_addr : (m.owner == 2) ? dc_addr : 32'h0);
    check1("l2_rd_en", l2_mem_rd_en,
           (m.owner == 1) ? ic_rd_en : (m.owner == 2) ? dc_rd_en : 1'b0);
    check1("l2_wr_en", l2_mem_wr_en,
           (m.owner == 1) ? ic_wr_en : (m.owner == 2) ? dc_wr_en : 1'b0);
    check32("l2_wr_data", l2_mem_wr_data,
            (m.owner == 1) ? ic_wr_data : (m.owner == 2) ? dc_wr_data : 32'h0);
    check32("rd_data_pass", rd_data, l2_mem_rd_data);
    if (m_icv || m_dcv) check32("rd_word", rd_data, mem_word(m_rd_addr));
    ic_vld_cnt += int'(ic_rd_vld);
    dc_gnt_cnt += int'(dc_gnt);
    to_cnt     += int'(timeout);
    to_ic_cnt  += int'(timeout && ic_gnt);
    bad_wr_cnt += int'(l2_mem_wr_en && l2_mem_wr_data == 32'hDEAD_BEEF);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int s0, s1, s2, s3;
    rst_n = 1'b0;
    #2;
    check1("rst_ic_gnt", ic_gnt, 1'b0);
    check1("rst_dc_gnt", dc_gnt, 1'b0);
    check1("rst_l2_rd_en", l2_mem_rd_en, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // IC-only burst of 8 reads
    s0 = ic_vld_cnt;
    s1 = dc_gnt_cnt;
    ic_req = 1'b1;
    step();
    check1("ic_grant_lat1", ic_gnt, 1'b1);
    for (int i = 0; i < 8; i++) begin
      ic_rd_en = 1'b1;
      ic_addr  = 32'h100 + 32'(i);
      step();
      if (i == 0) begin
        check1("first_ic_vld", ic_rd_vld, 1'b1);
        check32("first_rd_word", rd_data, 32'h0100_FEFF);
      end
    end
    ic_rd_en = 1'b0;
    ic_req   = 1'b0;
    step();
    step();
    check32("ic_vld_pulses", 32'(ic_vld_cnt - s0), 32'd8);
    check32("dc_never_granted", 32'(dc_gnt_cnt - s1), 32'd0);

    // Contention from reset pointer, zero-bubble handoff
    do_reset();
    ic_req = 1'b1;
    dc_req = 1'b1;
    step();
    check1("rr_ic_first", ic_gnt, 1'b1);
    check1("rr_dc_waits", dc_gnt, 1'b0);
    step();
    ic_req = 1'b0;
    step();
    check1("handoff_dc", dc_gnt, 1'b1);
    check1("handoff_ic_off", ic_gnt, 1'b0);
    dc_req = 1'b0;
    step();
    ic_req = 1'b1;
    dc_req = 1'b1;
    step();
    check1("ptr_back_ic", ic_gnt, 1'b1);
    ic_req = 1'b0;
    dc_req = 1'b0;
    step();
    step();

    // DC holds past the grant limit while IC waits
    s0 = dc_gnt_cnt;
    s1 = to_cnt;
    s2 = to_ic_cnt;
    dc_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 2) ic_req = 1'b1;
    end
    check32("dc_granted_cycles", 32'(dc_gnt_cnt - s0), 32'd16);
    check32("timeout_pulses", 32'(to_cnt - s1), 32'd1);
    check32("timeout_with_ic", 32'(to_ic_cnt - s2), 32'd1);
    check1("ic_after_revoke", ic_gnt, 1'b1);
    ic_req = 1'b0;
    step();
    check1("dc_regranted", dc_gnt, 1'b1);
    dc_req = 1'b0;
    step();
    step();

    // Non-granted DC write is masked; simultaneous IC rd+wr passes through
    s3 = bad_wr_cnt;
    ic_req = 1'b1;
    step();
    dc_req     = 1'b1;
    dc_wr_en   = 1'b1;
    dc_wr_data = 32'hDEAD_BEEF;
    dc_addr    = 32'h200;
    repeat (4) step();
    check1("dc_wr_masked", l2_mem_wr_en, 1'b0);
    check32("no_deadbeef_write", 32'(bad_wr_cnt - s3), 32'd0);
    ic_rd_en   = 1'b1;
    ic_wr_en   = 1'b1;
    ic_addr    = 32'h44;
    ic_wr_data = 32'h1234_5678;
    #1;
    check1("rdwr_both_rd", l2_mem_rd_en, 1'b1);
    check1("rdwr_both_wr", l2_mem_wr_en, 1'b1);
    step();

    // IC read in its last granted cycle, then handoff to DC
    ic_wr_en = 1'b0;
    dc_wr_en = 1'b0;
    ic_req   = 1'b0;
    ic_rd_en = 1'b1;
    ic_addr  = 32'h300;
    step();
    check1("last_rd_dc_gnt", dc_gnt, 1'b1);
    check1("last_rd_ic_vld", ic_rd_vld, 1'b1);
    check1("last_rd_dc_vld", dc_rd_vld, 1'b0);
    check32("last_rd_word", rd_data, 32'h0300_FCFF);
    ic_rd_en = 1'b0;
    dc_req   = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of an IC burst
    ic_req = 1'b1;
    step();
    ic_req = 1'b0;
    step();
    ic_req   = 1'b1;
    ic_rd_en = 1'b1;
    ic_addr  = 32'h500;
    step();
    step();
    check1("pre_rst_vld", ic_rd_vld, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check1("async_gnt_drop", ic_gnt, 1'b0);
    check1("async_vld_drop", ic_rd_vld, 1'b0);
    check1("async_l2_rd_off", l2_mem_rd_en, 1'b0);
    ic_req   = 1'b0;
    ic_rd_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    check1("post_rst_idle", ic_gnt, 1'b0);
    check1("post_rst_no_vld", ic_rd_vld, 1'b0);
    ic_req = 1'b1;
    dc_req = 1'b1;
    step();
    check1("post_rst_ptr0", ic_gnt, 1'b1);
    ic_req = 1'b0;
    dc_req = 1'b0;
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
